// File: rtl/sobel_rgb_axis_mul_arbiter.sv
// Round-robin arbiter sharing one unsigned DIN_WIDTH x DIN_WIDTH multiplier
// between NUM_REQ requesters. One operation is in flight at a time:
// IDLE (grant + operand capture) -> CALC (multiply) -> RESP (hold until taken).
module sobel_rgb_axis_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 31,
    parameter int DOUT_WIDTH = 62
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_din0,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_din1,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DOUT_WIDTH-1:0]          resp_dout,
    output logic                           busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDW-1:0]         r_rr_ptr;
    logic [IDW-1:0]         w_rr_ptr_next;
    logic [IDW-1:0]         r_gnt_id;
    logic [IDW-1:0]         w_gnt_idx;
    logic                   w_any;
    logic [IDW:0]           w_scan;
    logic [NUM_REQ-1:0]     w_gnt_onehot;
    logic                   w_resp_take;
    logic [DIN_WIDTH-1:0]   r_op0;
    logic [DIN_WIDTH-1:0]   r_op1;
    logic [DOUT_WIDTH-1:0]  r_dout;
    logic [DOUT_WIDTH-1:0]  w_prod;
    logic [DIN_WIDTH-1:0]   w_din0 [NUM_REQ];
    logic [DIN_WIDTH-1:0]   w_din1 [NUM_REQ];

    // Split the flat operand buses into one slice per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_din0[gi] = req_din0[gi*DIN_WIDTH +: DIN_WIDTH];
            assign w_din1[gi] = req_din1[gi*DIN_WIDTH +: DIN_WIDTH];
        end
    endgenerate

    // Both operands are zero-extended to the product width, so the result is exact.
    assign w_prod = DOUT_WIDTH'(r_op0) * DOUT_WIDTH'(r_op1);

    assign w_gnt_onehot = NUM_REQ'(1) << r_gnt_id;
    assign w_resp_take  = |(resp_ready & w_gnt_onehot);

    // Round-robin scan: walk downwards so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NUM_REQ)) begin
                w_scan = w_scan - (IDW+1)'(NUM_REQ);
            end
            if (req_valid[w_scan[IDW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_scan[IDW-1:0];
            end
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        w_rr_ptr_next = r_rr_ptr;
        req_ready     = '0;
        resp_valid    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_CALC;
                    // Reset must not let a requester believe it was accepted.
                    if (ap_rst_n) begin
                        req_ready = NUM_REQ'(1) << w_gnt_idx;
                    end
                end
            end
            S_CALC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = w_gnt_onehot;
                if (w_resp_take) begin
                    w_state_next  = S_IDLE;
                    w_rr_ptr_next = (r_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_op0    <= '0;
            r_op1    <= '0;
            r_dout   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_ptr_next;
            if (r_state == S_IDLE && w_any) begin
                r_gnt_id <= w_gnt_idx;
                r_op0    <= w_din0[w_gnt_idx];
                r_op1    <= w_din1[w_gnt_idx];
            end
            if (r_state == S_CALC) begin
                r_dout <= w_prod;
            end
        end
    end

    assign resp_dout = r_dout;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sobel_rgb_axis_mul_arbiter.sv
// Bench for the shared multiplier arbiter: a transaction-level model (one op
// in flight, age since grant, round-robin pointer) predicts every output each
// cycle; scripted scenarios add literal expectations on grants and products.
module tb_sobel_rgb_axis_mul_arbiter;

    localparam int N  = 4;
    localparam int DW = 31;
    localparam int OW = 62;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   din0;
    logic [N*DW-1:0]   din1;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [OW-1:0]     resp_dout;
    logic              busy;

    always #5 clk = ~clk;

    sobel_rgb_axis_mul_arbiter #(
        .NUM_REQ    (N),
        .DIN_WIDTH  (DW),
        .DOUT_WIDTH (OW)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_din0   (din0),
        .req_din1   (din1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dout  (resp_dout),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model
    bit            m_known = 0;
    int            m_rr    = 0;
    bit            m_busy  = 0;
    int            m_id    = 0;
    int            m_age   = 0;
    logic [OW-1:0] m_prod  = '0;
    logic [OW-1:0] m_dout  = '0;
    bit            auto_drop = 1;

    // Observations of the DUT, used for scenario-level literal checks
    int            grant_ids[$];
    int            grant_cyc[$];
    int            resp_ids[$];
    int            resp_cyc[$];
    logic [OW-1:0] resp_vals[$];

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d actual=timeout required=event", name, cyc);
    endtask

    // One clock: compare at negedge, advance model at posedge, drive after #1.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int g;
        int drop_id;
        longint unsigned a;
        longint unsigned b;
        @(negedge clk);
        g = -1;
        drop_id = -1;
        exp_ready = '0;
        exp_rv = '0;
        if (!m_busy && rst_n) begin
            g = pick(req_valid, m_rr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        if (m_busy && m_age == 2) exp_rv[m_id] = 1'b1;
        if (m_known) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("resp_valid", 64'(resp_valid), 64'(exp_rv));
            check("busy", 64'(busy), 64'(m_busy));
            check("resp_dout", 64'(resp_dout), 64'(m_dout));
        end
        if (req_ready != '0) begin
            grant_ids.push_back(pick(req_ready, 0));
            grant_cyc.push_back(cyc);
        end
        if ((resp_valid & resp_ready) != '0) begin
            resp_ids.push_back(pick(resp_valid, 0));
            resp_cyc.push_back(cyc);
            resp_vals.push_back(resp_dout);
            $display("cycle %0d: resp id=%0d dout=0x%0h", cyc, pick(resp_valid, 0), resp_dout);
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_known = 1;
            m_rr = 0;
            m_busy = 0;
            m_dout = '0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (g >= 0) begin
                    a = longint'(din0[g*DW +: DW]);
                    b = longint'(din1[g*DW +: DW]);
                    m_prod = OW'(a * b);
                    m_busy = 1;
                    m_id = g;
                    m_age = 1;
                    if (auto_drop) drop_id = g;
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_dout = m_prod;
            end else if (resp_ready[m_id]) begin
                m_busy = 0;
                m_rr = (m_id + 1) % N;
            end
        end
        #1;
        if (drop_id >= 0) req_valid[drop_id] = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i] = 1'b1;
        din0[i*DW +: DW] = a;
        din1[i*DW +: DW] = b;
    endtask

    task automatic run_until_resp(input int n, input int budget, input string name);
        int target;
        int k;
        target = resp_ids.size() + n;
        k = 0;
        while (resp_ids.size() < target && k < budget) begin
            cycle();
            k++;
        end
        if (resp_ids.size() < target) fail_timeout(name);
    endtask

    task automatic run_until_grant(input int budget, input string name);
        int target;
        int k;
        target = grant_ids.size() + 1;
        k = 0;
        while (grant_ids.size() < target && k < budget) begin
            cycle();
            k++;
        end
        if (grant_ids.size() < target) fail_timeout(name);
    endtask

    task automatic clear_logs();
        grant_ids.delete();
        grant_cyc.delete();
        resp_ids.delete();
        resp_cyc.delete();
        resp_vals.delete();
    endtask

    initial begin
        int nresp;
        rst_n = 1'b0;
        req_valid = '0;
        din0 = '0;
        din1 = '0;
        resp_ready = '1;
        @(posedge clk);
        #1;
        cycle();
        // requests while in reset must never see req_ready
        req_valid = '1;
        cycle();
        cycle();
        req_valid = '0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_dout", 64'(resp_dout), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Single request from requester 2
        clear_logs();
        set_op(2, 31'd3, 31'd5);
        run_until_resp(1, 10, "single_timeout");
        if (resp_ids.size() == 1 && grant_ids.size() == 1) begin
            check("single_grant_id", 64'(grant_ids[0]), 64'd2);
            check("single_resp_id", 64'(resp_ids[0]), 64'd2);
            check("single_dout", 64'(resp_vals[0]), 64'd15);
            check("single_latency", 64'(resp_cyc[0] - grant_cyc[0]), 64'd2);
        end
        check("single_model_rr", 64'(m_rr), 64'd3);

        // Wrap: pointer at 3, requesters 0 and 1 valid
        clear_logs();
        set_op(0, 31'd7, 31'd8);
        set_op(1, 31'd9, 31'd10);
        run_until_resp(2, 20, "wrap_timeout");
        if (grant_ids.size() >= 2 && resp_vals.size() >= 2) begin
            check("wrap_first", 64'(grant_ids[0]), 64'd0);
            check("wrap_second", 64'(grant_ids[1]), 64'd1);
            check("wrap_dout0", 64'(resp_vals[0]), 64'd56);
            check("wrap_dout1", 64'(resp_vals[1]), 64'd90);
        end

        // Max operands from requester 3
        clear_logs();
        set_op(3, 31'h7FFFFFFF, 31'h7FFFFFFF);
        run_until_resp(1, 20, "max_timeout");
        if (resp_vals.size() == 1)
            check("max_dout", 64'(resp_vals[0]), 64'h3FFFFFFF00000001);
        check("max_model_rr", 64'(m_rr), 64'd0);

        // Backpressure on requester 1 while others wait
        clear_logs();
        resp_ready = 4'b1101;
        set_op(1, 31'd1234, 31'd5678);
        run_until_grant(10, "bp_grant_timeout");
        set_op(0, 31'd2, 31'd3);
        set_op(2, 31'd4, 31'd5);
        repeat (6) cycle();
        check("bp_resp_valid", 64'(resp_valid), 64'b0010);
        check("bp_dout", 64'(resp_dout), 64'd7006652);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_no_extra_grant", 64'(grant_ids.size()), 64'd1);
        resp_ready = '1;
        run_until_resp(3, 30, "bp_release_timeout");
        if (grant_ids.size() == 3) begin
            check("bp_order_a", 64'(grant_ids[1]), 64'd2);
            check("bp_order_b", 64'(grant_ids[2]), 64'd0);
        end

        // Reset while an operation is in CALC
        repeat (3) cycle();
        clear_logs();
        set_op(0, 31'd11, 31'd13);
        run_until_grant(10, "rst_grant_timeout");
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_dout", 64'(resp_dout), 64'd0);
        repeat (6) cycle();
        check("midrst_no_resp", 64'(resp_ids.size()), 64'd0);
        check("midrst_model_rr", 64'(m_rr), 64'd0);

        // All four valid continuously from reset
        rst_n = 1'b0;
        auto_drop = 0;
        for (int i = 0; i < N; i++) set_op(i, DW'(i + 1), DW'(i + 2));
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
        repeat (16) cycle();
        if (grant_ids.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_order", 64'(grant_ids[i]), 64'(i % N));
                if (i > 0) check("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
            end
        end else begin
            fail_timeout("rr_grant_count");
        end
        req_valid = '0;
        auto_drop = 1;
        repeat (4) cycle();

        // Randomized traffic
        clear_logs();
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40)
                    set_op(i, DW'($urandom), DW'($urandom));
            end
            resp_ready = N'($urandom) | N'($urandom);
            cycle();
        end
        req_valid = '0;
        resp_ready = '1;
        repeat (6) cycle();
        nresp = resp_ids.size();
        check("rand_resp_count", 64'(nresp), 64'(grant_ids.size()));
        check("rand_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
